// File: rtl/rvfi_monitor_pkg.sv
// rvfi_monitor_pkg
// Shared definitions for the RVFI consistency monitor: error codes (numeric
// order doubles as reporting priority, lowest wins), the 32-bit opcodes that
// redirect control flow, and the legal-byte-mask classifier.
package rvfi_monitor_pkg;

  localparam logic [15:0] ERR_NONE     = 16'h0000;
  localparam logic [15:0] ERR_ORDER    = 16'h0101;
  localparam logic [15:0] ERR_PCCHAIN  = 16'h0102;
  localparam logic [15:0] ERR_PCALIGN  = 16'h0103;
  localparam logic [15:0] ERR_FALLTHRU = 16'h0104;
  localparam logic [15:0] ERR_RS1      = 16'h0201;
  localparam logic [15:0] ERR_RS2      = 16'h0202;
  localparam logic [15:0] ERR_X0READ   = 16'h0203;
  localparam logic [15:0] ERR_X0WRITE  = 16'h0204;
  localparam logic [15:0] ERR_RMASK    = 16'h0301;
  localparam logic [15:0] ERR_WMASK    = 16'h0302;
  localparam logic [15:0] ERR_BOTHMASK = 16'h0303;
  localparam logic [15:0] ERR_MADDR    = 16'h0304;

  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  // Byte, aligned halfword, or full word access patterns only.
  function automatic logic mask_legal(input logic [3:0] m);
    case (m)
      4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF: mask_legal = 1'b1;
      default:                                        mask_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rvfi_shadow_regfile.sv
// rvfi_shadow_regfile
// Shadow copy of the architectural integer register file as observed through
// RVFI writes. A valid bit per register records whether the value is known;
// only the valid bits are cleared by reset, the storage itself is not.
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   rs1_addr_i/rs2_addr_i    combinational read indices
//   rs1_data_o/rs2_data_o    shadow values
//   rs1_vld_o/rs2_vld_o      shadow value has been written since reset
//   we_i, wa_i, wd_i         write port (writes to x0 are dropped)
module rvfi_shadow_regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  rs1_addr_i,
  output logic [31:0] rs1_data_o,
  output logic        rs1_vld_o,
  input  logic [4:0]  rs2_addr_i,
  output logic [31:0] rs2_data_o,
  output logic        rs2_vld_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);

  logic [31:0] mem_q [32];
  logic [31:0] vld_q;
  logic        wr_en;

  assign wr_en = we_i && (wa_i != 5'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
    end else if (wr_en) begin
      vld_q[wa_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign rs1_data_o = mem_q[rs1_addr_i];
  assign rs1_vld_o  = vld_q[rs1_addr_i];
  assign rs2_data_o = mem_q[rs2_addr_i];
  assign rs2_vld_o  = vld_q[rs2_addr_i];

endmodule

// File: rtl/rvfi_monitor_rv32imc.sv
// rvfi_monitor_rv32imc
// RVFI consistency checker for a single-retire RV32IMC core. Checks retire
// order, PC chaining/alignment, straight-line next-PC, register reads against
// a shadow register file, x0 behaviour and memory mask legality. The first
// violation is latched in errcode (sticky until reset).
// Ports:
//   clock, reset             clock, asynchronous active-high reset
//   rvfi_*                   RVFI retire interface of the observed core
//   errcode                  0 = clean, otherwise first error code
module rvfi_monitor_rv32imc
  import rvfi_monitor_pkg::*;
#(
  parameter bit CHECK_FALLTHRU = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rvfi_valid,
  input  logic [63:0] rvfi_order,
  input  logic [31:0] rvfi_insn,
  input  logic        rvfi_trap,
  input  logic        rvfi_halt,
  input  logic        rvfi_intr,
  input  logic [1:0]  rvfi_mode,
  input  logic [4:0]  rvfi_rs1_addr,
  input  logic [4:0]  rvfi_rs2_addr,
  input  logic [31:0] rvfi_rs1_rdata,
  input  logic [31:0] rvfi_rs2_rdata,
  input  logic [4:0]  rvfi_rd_addr,
  input  logic [31:0] rvfi_rd_wdata,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [31:0] rvfi_pc_wdata,
  input  logic [31:0] rvfi_mem_addr,
  input  logic [3:0]  rvfi_mem_rmask,
  input  logic [3:0]  rvfi_mem_wmask,
  input  logic [31:0] rvfi_mem_rdata,
  input  logic [31:0] rvfi_mem_wdata,
  input  logic        rvfi_mem_extamo,
  output logic [15:0] errcode
);

  logic [15:0] err_q, err_d;
  logic        halted_q, halted_d;
  logic        first_q, first_d;
  logic [63:0] exp_order_q, exp_order_d;
  logic [31:0] last_pc_q;

  logic        commit;
  logic [31:0] sh_rs1_data, sh_rs2_data;
  logic        sh_rs1_vld, sh_rs2_vld;
  logic [15:0] chk_code;

  // Mode and memory data are outside the scope of these checks.
  logic unused_sink;
  assign unused_sink = ^{rvfi_mode, rvfi_mem_rdata, rvfi_mem_wdata,
                         rvfi_insn[31:16], rvfi_insn[12:7]};

  // rvfi_halt in the same cycle as a retire already suppresses that retire.
  assign commit = rvfi_valid && !halted_q && !rvfi_halt;

  rvfi_shadow_regfile u_shadow (
    .clk_i      (clock),
    .rst_i      (reset),
    .rs1_addr_i (rvfi_rs1_addr),
    .rs1_data_o (sh_rs1_data),
    .rs1_vld_o  (sh_rs1_vld),
    .rs2_addr_i (rvfi_rs2_addr),
    .rs2_data_o (sh_rs2_data),
    .rs2_vld_o  (sh_rs2_vld),
    .we_i       (commit),
    .wa_i       (rvfi_rd_addr),
    .wd_i       (rvfi_rd_wdata)
  );

  // Straight-line next-PC classification. Control-flow ops are exempt.
  logic       is_rvc;
  logic [6:0] opcode;
  logic [2:0] c_f3;
  logic       ft_skip;
  logic       ft_bad;

  assign is_rvc = (rvfi_insn[1:0] != 2'b11);
  assign opcode = rvfi_insn[6:0];
  assign c_f3   = rvfi_insn[15:13];

  always_comb begin
    ft_skip = 1'b0;
    if (!is_rvc) begin
      ft_skip = (opcode == OPC_JAL) || (opcode == OPC_JALR) ||
                (opcode == OPC_BRANCH) || (opcode == OPC_SYSTEM);
    end else if (rvfi_insn[1:0] == 2'b01) begin
      ft_skip = (c_f3 == 3'b001) || (c_f3 == 3'b101) ||
                (c_f3 == 3'b110) || (c_f3 == 3'b111);
    end else if (rvfi_insn[1:0] == 2'b10) begin
      ft_skip = (c_f3 == 3'b100) && (rvfi_insn[6:2] == 5'd0);
    end
  end

  assign ft_bad = CHECK_FALLTHRU && !rvfi_intr && !ft_skip &&
                  (rvfi_pc_wdata != (rvfi_pc_rdata + (is_rvc ? 32'd2 : 32'd4)));

  // Priority chain in ascending code order so the lowest code is reported.
  // A trapped retire is only checked for order.
  always_comb begin
    chk_code = ERR_NONE;
    if (rvfi_order != exp_order_q) begin
      chk_code = ERR_ORDER;
    end else if (!rvfi_trap) begin
      if (!first_q && !rvfi_intr && (rvfi_pc_rdata != last_pc_q)) begin
        chk_code = ERR_PCCHAIN;
      end else if (rvfi_pc_wdata[0]) begin
        chk_code = ERR_PCALIGN;
      end else if (ft_bad) begin
        chk_code = ERR_FALLTHRU;
      end else if ((rvfi_rs1_addr != 5'd0) && sh_rs1_vld && (rvfi_rs1_rdata != sh_rs1_data)) begin
        chk_code = ERR_RS1;
      end else if ((rvfi_rs2_addr != 5'd0) && sh_rs2_vld && (rvfi_rs2_rdata != sh_rs2_data)) begin
        chk_code = ERR_RS2;
      end else if (((rvfi_rs1_addr == 5'd0) && (rvfi_rs1_rdata != 32'd0)) ||
                   ((rvfi_rs2_addr == 5'd0) && (rvfi_rs2_rdata != 32'd0))) begin
        chk_code = ERR_X0READ;
      end else if ((rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0)) begin
        chk_code = ERR_X0WRITE;
      end else if (!mask_legal(rvfi_mem_rmask)) begin
        chk_code = ERR_RMASK;
      end else if (!mask_legal(rvfi_mem_wmask)) begin
        chk_code = ERR_WMASK;
      end else if ((rvfi_mem_rmask != 4'd0) && (rvfi_mem_wmask != 4'd0) && !rvfi_mem_extamo) begin
        chk_code = ERR_BOTHMASK;
      end else if (((rvfi_mem_rmask != 4'd0) || (rvfi_mem_wmask != 4'd0)) &&
                   (rvfi_mem_addr[1:0] != 2'b00)) begin
        chk_code = ERR_MADDR;
      end
    end
  end

  always_comb begin
    err_d       = err_q;
    halted_d    = halted_q | rvfi_halt;
    first_d     = first_q;
    exp_order_d = exp_order_q;
    if (commit) begin
      if (err_q == ERR_NONE) begin
        err_d = chk_code;
      end
      first_d     = 1'b0;
      exp_order_d = exp_order_q + 64'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q       <= ERR_NONE;
      halted_q    <= 1'b0;
      first_q     <= 1'b1;
      exp_order_q <= '0;
    end else begin
      err_q       <= err_d;
      halted_q    <= halted_d;
      first_q     <= first_d;
      exp_order_q <= exp_order_d;
    end
  end

  // Only meaningful once first_q has cleared, so it needs no reset.
  always_ff @(posedge clock) begin
    if (commit) begin
      last_pc_q <= rvfi_pc_wdata;
    end
  end

  assign errcode = err_q;

endmodule

// File: tb/tb_rvfi_monitor_rv32imc.sv
module tb_rvfi_monitor_rv32imc;

  localparam bit CHECK_FT = 1'b1;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic        rvfi_trap, rvfi_halt, rvfi_intr;
  logic [1:0]  rvfi_mode;
  logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
  logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr;
  logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
  logic [31:0] rvfi_mem_rdata, rvfi_mem_wdata;
  logic        rvfi_mem_extamo;
  logic [15:0] errcode;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  rvfi_monitor_rv32imc #(.CHECK_FALLTHRU(CHECK_FT)) dut (
    .clock(clock), .reset(reset), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt),
    .rvfi_intr(rvfi_intr), .rvfi_mode(rvfi_mode), .rvfi_rs1_addr(rvfi_rs1_addr),
    .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rs1_rdata(rvfi_rs1_rdata),
    .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
    .rvfi_mem_extamo(rvfi_mem_extamo), .errcode(errcode)
  );

  // ---------------- behavioural model ----------------
  logic [15:0] m_err;
  logic        m_halted, m_first;
  logic [63:0] m_order;
  logic [31:0] m_last;
  logic [31:0] m_sh [32];
  logic [31:0] m_sv;

  // Expected PC increment of a straight-line instruction, 0 = control flow.
  function automatic logic [31:0] insn_len(input logic [31:0] w);
    logic [2:0] f3;
    f3 = w[15:13];
    if (w[1:0] == 2'b11)
      return (w[6:0] inside {7'h6F, 7'h67, 7'h63, 7'h73}) ? 32'd0 : 32'd4;
    if (w[1:0] == 2'b01 && f3 inside {3'b001, 3'b101, 3'b110, 3'b111}) return 32'd0;
    if (w[1:0] == 2'b10 && f3 == 3'b100 && w[6:2] == 5'd0) return 32'd0;
    return 32'd2;
  endfunction

  function automatic bit mask_ok(input logic [3:0] m);
    return ($countones(m) == 1) || (m inside {4'h0, 4'h3, 4'hC, 4'hF});
  endfunction

  // Collect every violated rule, then report the numerically smallest.
  function automatic logic [15:0] model_code();
    logic [15:0] found[$];
    logic [15:0] best;
    logic [31:0] len;
    if (rvfi_order != m_order) found.push_back(16'h0101);
    if (!rvfi_trap) begin
      if (!m_first && !rvfi_intr && rvfi_pc_rdata != m_last) found.push_back(16'h0102);
      if (rvfi_pc_wdata[0]) found.push_back(16'h0103);
      len = insn_len(rvfi_insn);
      if (CHECK_FT && !rvfi_intr && len != 0 && rvfi_pc_wdata != rvfi_pc_rdata + len)
        found.push_back(16'h0104);
      if (rvfi_rs1_addr != 0 && m_sv[rvfi_rs1_addr] && rvfi_rs1_rdata != m_sh[rvfi_rs1_addr])
        found.push_back(16'h0201);
      if (rvfi_rs2_addr != 0 && m_sv[rvfi_rs2_addr] && rvfi_rs2_rdata != m_sh[rvfi_rs2_addr])
        found.push_back(16'h0202);
      if ((rvfi_rs1_addr == 0 && rvfi_rs1_rdata != 0) || (rvfi_rs2_addr == 0 && rvfi_rs2_rdata != 0))
        found.push_back(16'h0203);
      if (rvfi_rd_addr == 0 && rvfi_rd_wdata != 0) found.push_back(16'h0204);
      if (!mask_ok(rvfi_mem_rmask)) found.push_back(16'h0301);
      if (!mask_ok(rvfi_mem_wmask)) found.push_back(16'h0302);
      if (rvfi_mem_rmask != 0 && rvfi_mem_wmask != 0 && !rvfi_mem_extamo) found.push_back(16'h0303);
      if ((rvfi_mem_rmask != 0 || rvfi_mem_wmask != 0) && rvfi_mem_addr[1:0] != 0)
        found.push_back(16'h0304);
    end
    best = 16'h0;
    foreach (found[i]) if (best == 16'h0 || found[i] < best) best = found[i];
    return best;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_err <= 16'h0; m_halted <= 1'b0; m_first <= 1'b1; m_order <= 64'd0; m_sv <= 32'd0;
    end else begin
      if (rvfi_valid && !m_halted && !rvfi_halt) begin
        if (m_err == 16'h0) m_err <= model_code();
        m_order <= m_order + 64'd1;
        m_last  <= rvfi_pc_wdata;
        m_first <= 1'b0;
        if (rvfi_rd_addr != 0) begin
          m_sh[rvfi_rd_addr] <= rvfi_rd_wdata;
          m_sv[rvfi_rd_addr] <= 1'b1;
        end
      end
      if (rvfi_halt) m_halted <= 1'b1;
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clock) begin
    if (!reset) begin
      tests++;
      if (errcode !== m_err) begin
        fails++;
        $display("FAIL model_compare t=%0t errcode=%h model=%h", $time, errcode, m_err);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    rvfi_valid = 0; rvfi_order = 0; rvfi_insn = NOP; rvfi_trap = 0; rvfi_halt = 0;
    rvfi_intr = 0; rvfi_mode = 2'b11; rvfi_rs1_addr = 0; rvfi_rs2_addr = 0;
    rvfi_rs1_rdata = 0; rvfi_rs2_rdata = 0; rvfi_rd_addr = 0; rvfi_rd_wdata = 0;
    rvfi_pc_rdata = 0; rvfi_pc_wdata = 0; rvfi_mem_addr = 0; rvfi_mem_rmask = 0;
    rvfi_mem_wmask = 0; rvfi_mem_rdata = 0; rvfi_mem_wdata = 0; rvfi_mem_extamo = 0;
  endtask

  task automatic begin_commit(input logic [63:0] ord, input logic [31:0] insn,
                              input logic [31:0] pcr, input logic [31:0] pcw);
    idle();
    rvfi_valid = 1; rvfi_order = ord; rvfi_insn = insn;
    rvfi_pc_rdata = pcr; rvfi_pc_wdata = pcw;
  endtask

  task automatic finish_commit();
    @(posedge clock); #1;
    idle();
  endtask

  task automatic commit(input logic [63:0] ord, input logic [31:0] insn,
                        input logic [31:0] pcr, input logic [31:0] pcw);
    begin_commit(ord, insn, pcr, pcw);
    finish_commit();
  endtask

  // Asserted mid-cycle (called 1ns after a rising edge).
  task automatic do_reset();
    reset = 1; #3;
    @(posedge clock); #1 reset = 0;
  endtask

  task automatic check_lit(input string name, input logic [15:0] exp);
    tests++;
    if (errcode !== exp) begin
      fails++;
      $display("FAIL %s errcode=%h expected=%h", name, errcode, exp);
    end
  endtask

  initial begin
    idle(); reset = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    check_lit("reset_state", 16'h0000);

    // In-order straight-line run
    begin_commit(0, 32'h00100093, 32'h0, 32'h4); rvfi_rd_addr = 1; rvfi_rd_wdata = 1; finish_commit();
    check_lit("order0", 16'h0000);
    commit(1, NOP, 32'h4, 32'h8); check_lit("order1", 16'h0000);
    commit(2, NOP, 32'h8, 32'hC); check_lit("order2", 16'h0000);

    // Skipped order, sticky
    do_reset();
    commit(0, NOP, 32'h0, 32'h4);
    commit(2, NOP, 32'h4, 32'h8); check_lit("skip_order", 16'h0101);
    commit(3, NOP, 32'h8, 32'hC); check_lit("skip_order_sticky", 16'h0101);

    // Broken PC chain
    do_reset();
    commit(0, NOP, 32'hC, 32'h10);
    commit(1, NOP, 32'h14, 32'h18); check_lit("pc_chain", 16'h0102);

    // Stale register read
    do_reset();
    begin_commit(0, NOP, 32'h0, 32'h4); rvfi_rd_addr = 5; rvfi_rd_wdata = 32'hDEADBEEF; finish_commit();
    begin_commit(1, NOP, 32'h4, 32'h8); rvfi_rs1_addr = 5; rvfi_rs1_rdata = 32'h0; finish_commit();
    check_lit("rs1_stale", 16'h0201);
    do_reset();
    begin_commit(0, NOP, 32'h0, 32'h4); rvfi_rd_addr = 5; rvfi_rd_wdata = 32'hDEADBEEF; finish_commit();
    begin_commit(1, NOP, 32'h4, 32'h8); rvfi_rs1_addr = 5; rvfi_rs1_rdata = 32'hDEADBEEF; finish_commit();
    check_lit("rs1_match", 16'h0000);
    begin_commit(2, NOP, 32'h8, 32'hC); rvfi_rs2_addr = 5; rvfi_rs2_rdata = 32'h1; finish_commit();
    check_lit("rs2_stale", 16'h0202);

    // Mask legality
    do_reset();
    begin_commit(0, NOP, 32'h0, 32'h4); rvfi_mem_wmask = 4'b0110; finish_commit();
    check_lit("wmask_illegal", 16'h0302);
    do_reset();
    begin_commit(0, NOP, 32'h0, 32'h4); rvfi_mem_rmask = 4'b0011; rvfi_mem_wmask = 4'b0001; finish_commit();
    check_lit("both_mask", 16'h0303);
    do_reset();
    begin_commit(0, NOP, 32'h0, 32'h4); rvfi_mem_rmask = 4'hF; rvfi_mem_wmask = 4'hF;
    rvfi_mem_extamo = 1; finish_commit();
    check_lit("amo_both_ok", 16'h0000);
    begin_commit(1, NOP, 32'h4, 32'h8); rvfi_mem_rmask = 4'h1; rvfi_mem_addr = 32'h2; finish_commit();
    check_lit("mem_addr_unaligned", 16'h0304);

    // x0 rules
    do_reset();
    begin_commit(0, NOP, 32'h0, 32'h4); rvfi_rd_wdata = 32'h5; finish_commit();
    check_lit("x0_write", 16'h0204);
    do_reset();
    begin_commit(0, NOP, 32'h0, 32'h4); rvfi_rs2_rdata = 32'h7; finish_commit();
    check_lit("x0_read", 16'h0203);

    // Priority between simultaneous failures
    do_reset();
    commit(0, NOP, 32'h0, 32'h5); check_lit("align_over_fallthru", 16'h0103);
    do_reset();
    begin_commit(1, NOP, 32'h0, 32'h4); rvfi_rd_wdata = 32'h1; finish_commit();
    check_lit("order_over_x0write", 16'h0101);

    // Compressed and control-flow fallthrough rules, PC wrap
    do_reset();
    commit(0, 32'h00000001, 32'hFFFFFFFE, 32'h0);
    commit(1, 32'h0000A001, 32'h0, 32'h100);
    commit(2, 32'h00008082, 32'h100, 32'h40);
    commit(3, 32'h0000006F, 32'h40, 32'h80);
    commit(4, NOP, 32'h80, 32'h84);
    check_lit("cflow_ok", 16'h0000);
    commit(5, 32'h00004501, 32'h84, 32'h88); check_lit("rvc_fallthru", 16'h0104);

    // Trapped retire checks only order; interrupt entry breaks the chain
    do_reset();
    begin_commit(0, NOP, 32'h0, 32'h200); rvfi_trap = 1; rvfi_mem_wmask = 4'b0110;
    rvfi_mem_addr = 32'h1; finish_commit();
    commit(1, NOP, 32'h200, 32'h204);
    begin_commit(2, NOP, 32'h300, 32'h304); rvfi_intr = 1; finish_commit();
    check_lit("trap_intr_ok", 16'h0000);

    // Halt suppresses later checks
    do_reset();
    commit(0, NOP, 32'h0, 32'h4);
    rvfi_halt = 1; @(posedge clock); #1 rvfi_halt = 0;
    commit(5, NOP, 32'h44, 32'h48); check_lit("halted_ignore", 16'h0000);

    // Asynchronous reset clears a latched error immediately
    do_reset();
    commit(0, NOP, 32'h0, 32'h4);
    commit(7, NOP, 32'h4, 32'h8); check_lit("pre_reset_err", 16'h0101);
    reset = 1; #1 check_lit("async_reset", 16'h0000);
    #2; @(posedge clock); #1 reset = 0;
    commit(0, NOP, 32'h50, 32'h54); check_lit("post_reset_first", 16'h0000);
    commit(1, NOP, 32'h54, 32'h58); check_lit("post_reset_second", 16'h0000);

    @(negedge clock); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
